// File: rtl/cfg_regfile_bank.sv
// Parametrised configuration register bank: byte-enabled writes, pipelined
// reads with valid strobe, out-of-range error pulse, write lock and a
// saturating committed-write counter.
module cfg_regfile_bank #(
   parameter int                  ADDR_W     = 4,
   parameter int                  DATA_W     = 16,
   parameter int                  DEPTH      = 12,
   parameter int                  RD_LATENCY = 1,
   parameter logic [DATA_W-1:0]   RESET_VAL  = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_wr_en,
   input  logic                  io_rd_en,
   input  logic [ADDR_W-1:0]     io_address,
   input  logic [DATA_W-1:0]     io_write_data,
   input  logic [DATA_W/8-1:0]   io_byte_en,
   input  logic                  io_lock,
   output logic [DATA_W-1:0]     io_read_data,
   output logic                  io_read_valid,
   output logic                  io_error,
   output logic [15:0]           io_wr_count
);

   localparam int              NB      = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   logic [DATA_W-1:0]                    regs_q [DEPTH];
   logic [DATA_W-1:0]                    regs_d [DEPTH];
   logic [15:0]                          wr_cnt_q, wr_cnt_d;
   logic                                 wr_err_q, wr_err_d;
   logic [RD_LATENCY-1:0]                p_vld_q, p_vld_d;
   logic [RD_LATENCY-1:0]                p_err_q, p_err_d;
   logic [RD_LATENCY-1:0][DATA_W-1:0]    p_data_q, p_data_d;

   logic              in_range;
   logic              wr_hit;
   logic [DATA_W-1:0] rd_val;

   // Decode the shared address; unimplemented indices never alias onto storage.
   always_comb begin
      in_range = ({1'b0, io_address} < DEPTH_L);
      wr_hit   = io_wr_en & ~io_lock & in_range;
      rd_val   = '0;
      if (in_range) rd_val = regs_q[io_address];
   end

   // Storage update, write counter and write-side error.
   always_comb begin
      regs_d   = regs_q;
      wr_cnt_d = wr_cnt_q;
      wr_err_d = io_wr_en & (io_lock | ~in_range);
      if (wr_hit) begin
         for (int b = 0; b < NB; b++)
            if (io_byte_en[b]) regs_d[io_address][8*b +: 8] = io_write_data[8*b +: 8];
         // A zero byte enable still counts as a committed write.
         if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end
   end

   // Read pipeline: data is captured at the request edge (pre-write value),
   // and each stage only reloads when a valid entry moves in, so the last
   // stage holds its value while no read is returning.
   always_comb begin
      p_vld_d     = '0;
      p_err_d     = '0;
      p_data_d    = p_data_q;
      p_vld_d[0]  = io_rd_en;
      p_err_d[0]  = io_rd_en & ~in_range;
      if (io_rd_en) p_data_d[0] = rd_val;
      for (int k = 1; k < RD_LATENCY; k++) begin
         p_vld_d[k] = p_vld_q[k-1];
         p_err_d[k] = p_err_q[k-1];
         if (p_vld_q[k-1]) p_data_d[k] = p_data_q[k-1];
      end
   end

   // State registers; reset also flushes any read in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
         wr_cnt_q <= '0;
         wr_err_q <= 1'b0;
         p_vld_q  <= '0;
         p_err_q  <= '0;
         p_data_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         wr_cnt_q <= wr_cnt_d;
         wr_err_q <= wr_err_d;
         p_vld_q  <= p_vld_d;
         p_err_q  <= p_err_d;
         p_data_q <= p_data_d;
      end
   end

   // Write errors and read errors landing together merge into one pulse.
   always_comb begin
      io_read_data  = p_data_q[RD_LATENCY-1];
      io_read_valid = p_vld_q[RD_LATENCY-1];
      io_error      = wr_err_q | (p_vld_q[RD_LATENCY-1] & p_err_q[RD_LATENCY-1]);
      io_wr_count   = wr_cnt_q;
   end

endmodule

// File: tb/tb_cfg_regfile_bank.sv
// Directed bench for cfg_regfile_bank: one instance at read latency 1, one
// at latency 2 sharing the same bus but with its own reset.
module tb_cfg_regfile_bank;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic        wr_en, rd_en, lock;
   logic [3:0]  addr;
   logic [15:0] wdata;
   logic [1:0]  be;
   logic [15:0] rdata, rdata2, cnt, cnt2;
   logic        rvld, rvld2, err, err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cfg_regfile_bank #(.RD_LATENCY(1)) dut (
      .clock(clk), .reset(rst_n), .io_wr_en(wr_en), .io_rd_en(rd_en),
      .io_address(addr), .io_write_data(wdata), .io_byte_en(be), .io_lock(lock),
      .io_read_data(rdata), .io_read_valid(rvld), .io_error(err), .io_wr_count(cnt)
   );

   cfg_regfile_bank #(.RD_LATENCY(2)) dut2 (
      .clock(clk), .reset(rst2_n), .io_wr_en(wr_en), .io_rd_en(rd_en),
      .io_address(addr), .io_write_data(wdata), .io_byte_en(be), .io_lock(lock),
      .io_read_data(rdata2), .io_read_valid(rvld2), .io_error(err2), .io_wr_count(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Drive one bus cycle on the falling edge, then sample 1ns after the rising edge.
   task automatic cyc(input logic w, input logic r, input logic [3:0] a,
                      input logic [15:0] d, input logic [1:0] b, input logic l);
      @(negedge clk);
      wr_en = w; rd_en = r; addr = a; wdata = d; be = b; lock = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0);
   endtask

   logic [15:0] exp5 [4];
   logic [3:0]  adr5 [4];

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      wr_en = 0; rd_en = 0; lock = 0; addr = 0; wdata = 0; be = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, rvld}, 32'd0);
      chk("rst_error", {31'd0, err}, 32'd0);
      chk("rst_data", {16'd0, rdata}, 32'd0);
      chk("rst_count", {16'd0, cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;

      // T1: every implemented register reads back its reset value
      for (int a = 0; a < 12; a++) begin
         cyc(1'b0, 1'b1, a[3:0], 16'h0, 2'b00, 1'b0);
         chk($sformatf("t1_vld%0d", a), {31'd0, rvld}, 32'd1);
         chk($sformatf("t1_dat%0d", a), {16'd0, rdata}, 32'd0);
         chk($sformatf("t1_err%0d", a), {31'd0, err}, 32'd0);
      end
      idle();
      chk("t1_vld_off", {31'd0, rvld}, 32'd0);
      chk("t1_hold", {16'd0, rdata}, 32'd0);
      chk("t1_count", {16'd0, cnt}, 32'd0);

      // T2: low byte only
      cyc(1'b1, 1'b0, 4'd3, 16'hA5C3, 2'b01, 1'b0);
      chk("t2_err", {31'd0, err}, 32'd0);
      chk("t2_count", {16'd0, cnt}, 32'd1);
      cyc(1'b0, 1'b1, 4'd3, 16'h0, 2'b00, 1'b0);
      chk("t2_vld", {31'd0, rvld}, 32'd1);
      chk("t2_data", {16'd0, rdata}, 32'h00C3);

      // Upper byte only on top of existing value
      cyc(1'b1, 1'b0, 4'd7, 16'h1122, 2'b11, 1'b0);
      cyc(1'b1, 1'b0, 4'd7, 16'hFF00, 2'b10, 1'b0);
      cyc(1'b0, 1'b1, 4'd7, 16'h0, 2'b00, 1'b0);
      chk("t2_hibyte", {16'd0, rdata}, 32'hFF22);
      chk("t2_count3", {16'd0, cnt}, 32'd3);

      // T3: same-cycle read and write returns the old value
      cyc(1'b1, 1'b0, 4'd5, 16'h1234, 2'b11, 1'b0);
      cyc(1'b1, 1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b0);
      chk("t3_rbw_vld", {31'd0, rvld}, 32'd1);
      chk("t3_rbw_data", {16'd0, rdata}, 32'h1234);
      cyc(1'b0, 1'b1, 4'd5, 16'h0, 2'b00, 1'b0);
      chk("t3_new_data", {16'd0, rdata}, 32'hBEEF);
      chk("t3_count", {16'd0, cnt}, 32'd5);

      // T4: out-of-range write
      cyc(1'b1, 1'b0, 4'd12, 16'hDEAD, 2'b11, 1'b0);
      chk("t4_wr_oor_err", {31'd0, err}, 32'd1);
      chk("t4_wr_oor_vld", {31'd0, rvld}, 32'd0);
      chk("t4_wr_oor_cnt", {16'd0, cnt}, 32'd5);
      idle();
      chk("t4_err_pulse", {31'd0, err}, 32'd0);
      chk("t4_hold", {16'd0, rdata}, 32'hBEEF);

      // Locked write leaves storage and count alone
      cyc(1'b1, 1'b0, 4'd2, 16'h5555, 2'b11, 1'b0);
      chk("t4_pre_cnt", {16'd0, cnt}, 32'd6);
      cyc(1'b1, 1'b0, 4'd2, 16'hFFFF, 2'b11, 1'b1);
      chk("t4_lock_err", {31'd0, err}, 32'd1);
      chk("t4_lock_cnt", {16'd0, cnt}, 32'd6);
      cyc(1'b0, 1'b1, 4'd2, 16'h0, 2'b00, 1'b1);
      chk("t4_lock_rd_err", {31'd0, err}, 32'd0);
      chk("t4_lock_rd_vld", {31'd0, rvld}, 32'd1);
      chk("t4_lock_data", {16'd0, rdata}, 32'h5555);

      // Out-of-range reads
      cyc(1'b0, 1'b1, 4'd15, 16'h0, 2'b00, 1'b0);
      chk("t4_rd15_vld", {31'd0, rvld}, 32'd1);
      chk("t4_rd15_err", {31'd0, err}, 32'd1);
      chk("t4_rd15_data", {16'd0, rdata}, 32'd0);
      cyc(1'b0, 1'b1, 4'd12, 16'h0, 2'b00, 1'b0);
      chk("t4_rd12_err", {31'd0, err}, 32'd1);
      idle();
      chk("t4_rd_err_off", {31'd0, err}, 32'd0);

      // Write error and read error in the same cycle: one pulse only
      cyc(1'b1, 1'b1, 4'd13, 16'h0, 2'b11, 1'b0);
      chk("t4_both_err", {31'd0, err}, 32'd1);
      idle();
      chk("t4_both_off", {31'd0, err}, 32'd0);
      chk("t4_cnt_final", {16'd0, cnt}, 32'd6);

      // T6: zero-byte-enable writes commit (count) but change nothing
      @(negedge clk);
      wr_en = 1'b1; rd_en = 1'b0; addr = 4'd0; wdata = 16'hFFFF; be = 2'b00; lock = 1'b0;
      repeat (16'hFFFE - 6) @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      chk("t6_cnt_fffe", {16'd0, cnt}, 32'h0000FFFE);
      cyc(1'b0, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0);
      chk("t6_be0_data", {16'd0, rdata}, 32'd0);
      cyc(1'b1, 1'b0, 4'd1, 16'h0001, 2'b11, 1'b0);
      chk("t6_cnt_ffff", {16'd0, cnt}, 32'h0000FFFF);
      cyc(1'b1, 1'b0, 4'd1, 16'h0002, 2'b11, 1'b0);
      cyc(1'b1, 1'b0, 4'd1, 16'h0003, 2'b11, 1'b0);
      chk("t6_cnt_sat", {16'd0, cnt}, 32'h0000FFFF);
      chk("t6_cnt2_sat", {16'd0, cnt2}, 32'h0000FFFF);
      idle();

      // T5: latency-2 instance, 4 back-to-back reads
      adr5[0] = 4'd3; exp5[0] = 16'h00C3;
      adr5[1] = 4'd5; exp5[1] = 16'hBEEF;
      adr5[2] = 4'd2; exp5[2] = 16'h5555;
      adr5[3] = 4'd1; exp5[3] = 16'h0003;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) cyc(1'b0, 1'b1, adr5[i], 16'h0, 2'b00, 1'b0);
         else       idle();
         if (i == 0 || i == 5) chk($sformatf("t5_vld_off%0d", i), {31'd0, rvld2}, 32'd0);
         else begin
            chk($sformatf("t5_vld%0d", i), {31'd0, rvld2}, 32'd1);
            chk($sformatf("t5_dat%0d", i), {16'd0, rdata2}, {16'd0, exp5[i-1]});
         end
      end

      // Out-of-range read at latency 2: error aligned with valid
      cyc(1'b0, 1'b1, 4'd14, 16'h0, 2'b00, 1'b0);
      chk("t5_oor_early", {31'd0, err2}, 32'd0);
      idle();
      chk("t5_oor_vld", {31'd0, rvld2}, 32'd1);
      chk("t5_oor_err", {31'd0, err2}, 32'd1);
      chk("t5_oor_data", {16'd0, rdata2}, 32'd0);

      // Reset one cycle after a read flushes it
      cyc(1'b0, 1'b1, 4'd5, 16'h0, 2'b00, 1'b0);
      @(negedge clk);
      rd_en = 1'b0;
      rst2_n = 1'b0;
      #1;
      chk("t5_flush_now", {31'd0, rvld2}, 32'd0);
      chk("t5_flush_cnt", {16'd0, cnt2}, 32'd0);
      @(posedge clk); #1;
      chk("t5_flush_vld1", {31'd0, rvld2}, 32'd0);
      @(negedge clk);
      rst2_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("t5_flush_vld%0d", i + 2), {31'd0, rvld2}, 32'd0);
      end
      chk("t5_flush_data", {16'd0, rdata2}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
